// File: rtl/spi_responder.sv
// SPI mode-0 target on the system clock: oversamples SCLK/CS/MOSI, decodes
// an address byte then a data byte, serves an 8-entry register file plus a
// read-only WHOAMI register, and returns read data during the data byte.
module spi_responder #(
    parameter logic [6:0] WHOAMI_ADDR  = 7'h78,
    parameter logic [7:0] WHOAMI_VALUE = 8'h5A,
    parameter logic [7:0] REG_RESET    = 8'h00
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_sclk,
    input  logic       i_cs_n,
    input  logic       i_mosi,
    output logic       o_miso,
    output logic       o_wr_strobe,
    output logic [2:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic       o_frame_error,
    output logic [7:0] o_mode
);

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Synchroniser chains; the third SCLK flop only feeds edge detection
    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic cs_s1_q, cs_s2_q;
    logic mosi_s1_q, mosi_s2_q;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       rx_q;
    logic [7:0]       addr_q;
    logic [7:0]       tx_q;
    logic             miso_q;
    logic             wr_strobe_q;
    logic [2:0]       wr_addr_q;
    logic [7:0]       wr_data_q;
    logic             frame_error_q;
    logic [7:0]       regs_q [NUM_REGS];

    logic       sclk_rise_c;
    logic       sclk_fall_c;
    logic [7:0] rx_next_c;
    logic [7:0] rd_val_c;
    logic       wr_valid_c;

    // Bring the asynchronous SPI pins into the i_clock domain
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            sclk_s1_q <= i_sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            cs_s1_q   <= i_cs_n;
            cs_s2_q   <= cs_s1_q;
            mosi_s1_q <= i_mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    // Edge detection, shift-in value and read-data lookup for the address byte
    always_comb begin
        sclk_rise_c = sclk_s2_q & ~sclk_s3_q;
        sclk_fall_c = ~sclk_s2_q & sclk_s3_q;
        rx_next_c   = {rx_q[6:0], mosi_s2_q};
        rd_val_c    = 8'h00;
        if (rx_next_c[6:3] == 4'd0) begin
            rd_val_c = regs_q[rx_next_c[2:0]];
        end else if (rx_next_c[6:0] == WHOAMI_ADDR) begin
            rd_val_c = WHOAMI_VALUE;
        end
        // Only register-file indices of a write frame commit
        wr_valid_c  = ~addr_q[7] && (addr_q[6:3] == 4'd0);
    end

    // Frame FSM, register file and registered outputs
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            rx_q          <= '0;
            addr_q        <= '0;
            tx_q          <= '0;
            miso_q        <= 1'b0;
            wr_strobe_q   <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_error_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= REG_RESET;
            end
        end else begin
            wr_strobe_q   <= 1'b0;
            frame_error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    miso_q <= 1'b0;
                    if (!cs_s2_q) begin
                        cnt_q   <= '0;
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    miso_q <= 1'b0;
                    if (cs_s2_q) begin
                        frame_error_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else if (sclk_rise_c) begin
                        rx_q  <= rx_next_c;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(7)) begin
                            addr_q  <= rx_next_c;
                            tx_q    <= rx_next_c[7] ? rd_val_c : 8'h00;
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (cs_s2_q) begin
                        miso_q        <= 1'b0;
                        frame_error_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else if (sclk_fall_c) begin
                        miso_q <= tx_q[7];
                        tx_q   <= {tx_q[6:0], 1'b0};
                    end else if (sclk_rise_c) begin
                        rx_q  <= rx_next_c;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(15)) begin
                            miso_q  <= 1'b0;
                            state_q <= ST_DONE;
                            if (wr_valid_c) begin
                                regs_q[addr_q[2:0]] <= rx_next_c;
                                wr_strobe_q         <= 1'b1;
                                wr_addr_q           <= addr_q[2:0];
                                wr_data_q           <= rx_next_c;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    miso_q <= 1'b0;
                    if (cs_s2_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    miso_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_miso        = miso_q;
    assign o_wr_strobe   = wr_strobe_q;
    assign o_wr_addr     = wr_addr_q;
    assign o_wr_data     = wr_data_q;
    assign o_frame_error = frame_error_q;
    assign o_mode        = regs_q[0];

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: drives SPI frames bit by bit from the
// system-clock negedge and checks read data, strobes and frame errors.
module tb_spi_responder;

    localparam int unsigned HALF = 6;

    logic       clk;
    logic       rst;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       wr_strobe;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_error;
    logic [7:0] mode;

    int checks;
    int errors;
    int strobe_cnt;
    int ferr_cnt;
    int miso_hi_cnt;
    int snap_strobe;
    int snap_ferr;
    int snap_miso;
    logic [23:0] rx;

    spi_responder dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_sclk        (sclk),
        .i_cs_n        (cs_n),
        .i_mosi        (mosi),
        .o_miso        (miso),
        .o_wr_strobe   (wr_strobe),
        .o_wr_addr     (wr_addr),
        .o_wr_data     (wr_data),
        .o_frame_error (frame_error),
        .o_mode        (mode)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Event counters sampled away from the active edge
    initial begin
        strobe_cnt  = 0;
        ferr_cnt    = 0;
        miso_hi_cnt = 0;
    end
    always @(negedge clk) begin
        if (wr_strobe === 1'b1)   strobe_cnt++;
        if (frame_error === 1'b1) ferr_cnt++;
        if (miso === 1'b1)        miso_hi_cnt++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send nbits MSB-first from a left-aligned 24-bit vector; MISO is
    // captured just before each rise, the point where the initiator samples
    task automatic spi_xfer(input logic [23:0] tx, input int nbits,
                            input bit raise_cs, output logic [23:0] rxv);
        rxv = '0;
        cs_n = 1'b0;
        wait_cyc(HALF);
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[23-i];
            wait_cyc(HALF);
            rxv[23-i] = miso;
            sclk = 1'b1;
            wait_cyc(HALF);
            sclk = 1'b0;
        end
        wait_cyc(HALF);
        if (raise_cs) begin
            cs_n = 1'b1;
            mosi = 1'b0;
            wait_cyc(8);
        end
    endtask

    task automatic snap();
        snap_strobe = strobe_cnt;
        snap_ferr   = ferr_cnt;
        snap_miso   = miso_hi_cnt;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b1;
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_cyc(3);

        // Reset values
        check("rst_miso", 32'(miso), 32'h0);
        check("rst_strobe", 32'(wr_strobe), 32'h0);
        check("rst_wr_addr", 32'(wr_addr), 32'h0);
        check("rst_wr_data", 32'(wr_data), 32'h0);
        check("rst_ferr", 32'(frame_error), 32'h0);
        check("rst_mode", 32'(mode), 32'h00);
        rst = 1'b0;
        wait_cyc(4);

        // WHOAMI read
        snap();
        spi_xfer({8'hF8, 8'h00, 8'h00}, 16, 1'b1, rx);
        check("whoami_rd", 32'(rx[15:8]), 32'h5A);
        check("whoami_no_strobe", 32'(strobe_cnt - snap_strobe), 32'd0);
        check("whoami_no_ferr", 32'(ferr_cnt - snap_ferr), 32'd0);

        // Mode register write then read back
        snap();
        spi_xfer({8'h00, 8'hC3, 8'h00}, 16, 1'b1, rx);
        check("wr0_strobes", 32'(strobe_cnt - snap_strobe), 32'd1);
        check("wr0_addr", 32'(wr_addr), 32'h0);
        check("wr0_data", 32'(wr_data), 32'hC3);
        check("wr0_mode", 32'(mode), 32'hC3);
        check("wr0_miso_quiet", 32'(miso_hi_cnt - snap_miso), 32'd0);
        spi_xfer({8'h80, 8'h00, 8'h00}, 16, 1'b1, rx);
        check("rd0", 32'(rx[15:8]), 32'hC3);

        // Valid write, then write to read-only WHOAMI
        snap();
        spi_xfer({8'h05, 8'h3C, 8'h00}, 16, 1'b1, rx);
        spi_xfer({8'h78, 8'hFF, 8'h00}, 16, 1'b1, rx);
        check("wr5_ro_strobes", 32'(strobe_cnt - snap_strobe), 32'd1);
        check("wr5_addr_held", 32'(wr_addr), 32'h5);
        check("wr5_data_held", 32'(wr_data), 32'h3C);
        spi_xfer({8'h85, 8'h00, 8'h00}, 16, 1'b1, rx);
        check("rd5", 32'(rx[15:8]), 32'h3C);
        spi_xfer({8'hF8, 8'h00, 8'h00}, 16, 1'b1, rx);
        check("whoami_after_wr", 32'(rx[15:8]), 32'h5A);

        // Short frame aborts after 11 bits
        snap();
        spi_xfer({8'h02, 8'hAA, 8'h00}, 11, 1'b1, rx);
        check("abort_ferr", 32'(ferr_cnt - snap_ferr), 32'd1);
        check("abort_no_strobe", 32'(strobe_cnt - snap_strobe), 32'd0);
        spi_xfer({8'h82, 8'h00, 8'h00}, 16, 1'b1, rx);
        check("rd2_unwritten", 32'(rx[15:8]), 32'h00);

        // 20-bit frame: trailing 4 bits ignored
        snap();
        spi_xfer({8'h01, 8'h77, 8'hF0}, 20, 1'b1, rx);
        check("long_strobes", 32'(strobe_cnt - snap_strobe), 32'd1);
        check("long_addr", 32'(wr_addr), 32'h1);
        check("long_data", 32'(wr_data), 32'h77);
        check("long_miso_quiet", 32'(miso_hi_cnt - snap_miso), 32'd0);
        check("long_no_ferr", 32'(ferr_cnt - snap_ferr), 32'd0);
        check("long_mode_kept", 32'(mode), 32'hC3);
        spi_xfer({8'h81, 8'h00, 8'h00}, 16, 1'b1, rx);
        check("rd1", 32'(rx[15:8]), 32'h77);

        // Reset in the middle of a write to index 3
        snap();
        spi_xfer({8'h03, 8'h11, 8'h00}, 6, 1'b0, rx);
        rst = 1'b1;
        wait_cyc(2);
        check("midrst_miso", 32'(miso), 32'h0);
        check("midrst_strobe", 32'(wr_strobe), 32'h0);
        check("midrst_wr_addr", 32'(wr_addr), 32'h0);
        check("midrst_wr_data", 32'(wr_data), 32'h0);
        check("midrst_ferr", 32'(frame_error), 32'h0);
        check("midrst_mode", 32'(mode), 32'h00);
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(4);
        check("midrst_no_strobe", 32'(strobe_cnt - snap_strobe), 32'd0);
        snap();
        spi_xfer({8'h03, 8'h11, 8'h00}, 16, 1'b1, rx);
        check("post_rst_strobes", 32'(strobe_cnt - snap_strobe), 32'd1);
        check("post_rst_addr", 32'(wr_addr), 32'h3);
        check("post_rst_data", 32'(wr_data), 32'h11);
        check("post_rst_no_ferr", 32'(ferr_cnt - snap_ferr), 32'd0);
        spi_xfer({8'h83, 8'h00, 8'h00}, 16, 1'b1, rx);
        check("rd3", 32'(rx[15:8]), 32'h11);
        spi_xfer({8'h80, 8'h00, 8'h00}, 16, 1'b1, rx);
        check("rd0_after_rst", 32'(rx[15:8]), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
